// File: rtl/binary_encoder_pkg.sv
// Shared definitions for the binary value encoder: value width, action
// encoding, default timing constants and the action priority function.
package binary_encoder_pkg;

   localparam int VALUE_W                 = 8;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
   localparam int DEFAULT_REPEAT_DELAY    = 50000000;
   localparam int DEFAULT_REPEAT_PERIOD   = 10000000;

   typedef enum logic [2:0] {
      NONE,
      CLEAR,
      LOAD,
      INC,
      DEC
   } action_e;

   // Clear beats load beats inc/dec; simultaneous inc and dec cancel out.
   function automatic action_e select_action(input logic clr,
                                             input logic ld,
                                             input logic inc,
                                             input logic dec);
      action_e act;
      act = NONE;
      if (clr) begin
         act = CLEAR;
      end else if (ld) begin
         act = LOAD;
      end else if (inc && !dec) begin
         act = INC;
      end else if (dec && !inc) begin
         act = DEC;
      end
      return act;
   endfunction

endpackage

// File: rtl/binary_value_encoder_debouncer.sv
// button_debouncer: 2-flop synchroniser, debounce counter, stable state and
// a registered single-cycle press event for one raw button.
// Optional auto-repeat (BINARY_ENCODER_AUTO_REPEAT_EN): while the button stays
// stable-high, extra events fire REPEAT_DELAY cycles after the press and then
// every REPEAT_PERIOD cycles; only instances with REPEAT_EN set repeat.
module button_debouncer
   import binary_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef BINARY_ENCODER_AUTO_REPEAT_EN
   ,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press_evt
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             evt_q, evt_d;
   logic             press;

   // Synchronise, then accept a new level only after it has disagreed with
   // the stable state for DEBOUNCE_CYCLES+1 consecutive samples.
   always_comb begin
      sync1_d  = btn_raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      press    = 1'b0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
            stable_d = sync2_q;
            press    = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef BINARY_ENCODER_AUTO_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             rep_phase_q, rep_phase_d;
   logic             rep_fire;

   // Repeat timer runs only while the debounced level stays high; phase 0 is
   // the initial hold delay, phase 1 the periodic interval.
   always_comb begin
      rep_cnt_d   = rep_cnt_q + REP_W'(1);
      rep_phase_d = rep_phase_q;
      rep_fire    = 1'b0;
      if (!REPEAT_EN || !stable_d || press) begin
         rep_cnt_d   = '0;
         rep_phase_d = 1'b0;
      end else if ((!rep_phase_q && (rep_cnt_q == REP_W'(REPEAT_DELAY - 1))) ||
                   ( rep_phase_q && (rep_cnt_q == REP_W'(REPEAT_PERIOD - 1)))) begin
         rep_fire    = 1'b1;
         rep_cnt_d   = '0;
         rep_phase_d = 1'b1;
      end
   end

   // Repeat timer state.
   always_ff @(posedge clk) begin
      if (reset) begin
         rep_cnt_q   <= '0;
         rep_phase_q <= 1'b0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_phase_q <= rep_phase_d;
      end
   end

   assign evt_d = press | rep_fire;
`else
   assign evt_d = press;
`endif

   // Synchroniser, debounce state and registered event.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         evt_q    <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         evt_q    <= evt_d;
      end
   end

   assign press_evt = evt_q;

endmodule

// File: rtl/binary_value_encoder.sv
// binary_value_encoder: turns slide switches and four debounced buttons into
// a held 8-bit value with a one-cycle strobe on every applied action.
// Optional auto-repeat on inc/dec via BINARY_ENCODER_AUTO_REPEAT_EN.
module binary_value_encoder
   import binary_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [VALUE_W-1:0] switches,
   input  logic               btnLoad,
   input  logic               btnInc,
   input  logic               btnDec,
   input  logic               btnClear,
   output logic [VALUE_W-1:0] value,
   output logic               valueStrobe
);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("binary_value_encoder: timing parameters must be at least 1");
   end

   logic [VALUE_W-1:0] sw_sync1_q, sw_sync1_d;
   logic [VALUE_W-1:0] sw_sync2_q, sw_sync2_d;
   logic [VALUE_W-1:0] value_q, value_d;
   logic               strobe_q, strobe_d;
   logic               load_evt, inc_evt, dec_evt, clr_evt;
   action_e            action;

`ifdef BINARY_ENCODER_AUTO_REPEAT_EN
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0),
                      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
      u_db_load  (.clk(clk), .reset(reset), .btn_raw(btnLoad),  .press_evt(load_evt));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
                      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
      u_db_inc   (.clk(clk), .reset(reset), .btn_raw(btnInc),   .press_evt(inc_evt));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
                      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
      u_db_dec   (.clk(clk), .reset(reset), .btn_raw(btnDec),   .press_evt(dec_evt));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0),
                      .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
      u_db_clear (.clk(clk), .reset(reset), .btn_raw(btnClear), .press_evt(clr_evt));
`else
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
      u_db_load  (.clk(clk), .reset(reset), .btn_raw(btnLoad),  .press_evt(load_evt));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
      u_db_inc   (.clk(clk), .reset(reset), .btn_raw(btnInc),   .press_evt(inc_evt));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
      u_db_dec   (.clk(clk), .reset(reset), .btn_raw(btnDec),   .press_evt(dec_evt));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
      u_db_clear (.clk(clk), .reset(reset), .btn_raw(btnClear), .press_evt(clr_evt));
`endif

   // Pick one action per cycle and compute the next value; load uses the
   // synchronised switches so an asynchronous edge never reaches value.
   always_comb begin
      sw_sync1_d = switches;
      sw_sync2_d = sw_sync1_q;
      action     = select_action(clr_evt, load_evt, inc_evt, dec_evt);
      value_d    = value_q;
      strobe_d   = 1'b0;
      case (action)
         CLEAR: begin
            value_d  = '0;
            strobe_d = 1'b1;
         end
         LOAD: begin
            value_d  = sw_sync2_q;
            strobe_d = 1'b1;
         end
         INC: begin
            value_d  = value_q + VALUE_W'(1);
            strobe_d = 1'b1;
         end
         DEC: begin
            value_d  = value_q - VALUE_W'(1);
            strobe_d = 1'b1;
         end
         default: begin
            value_d  = value_q;
            strobe_d = 1'b0;
         end
      endcase
   end

   // Switch synchroniser, held value and strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_sync1_q <= '0;
         sw_sync2_q <= '0;
         value_q    <= '0;
         strobe_q   <= 1'b0;
      end else begin
         sw_sync1_q <= sw_sync1_d;
         sw_sync2_q <= sw_sync2_d;
         value_q    <= value_d;
         strobe_q   <= strobe_d;
      end
   end

   assign value       = value_q;
   assign valueStrobe = strobe_q;

endmodule

// File: tb/tb_binary_value_encoder.sv
// Scoreboard bench for binary_value_encoder with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8. Honours BINARY_ENCODER_AUTO_REPEAT_EN.
module tb_binary_value_encoder;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] switches;
   logic       btnLoad, btnInc, btnDec, btnClear;
   logic [7:0] value;
   logic       valueStrobe;

   binary_value_encoder #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (20),
      .REPEAT_PERIOD  (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .switches   (switches),
      .btnLoad    (btnLoad),
      .btnInc     (btnInc),
      .btnDec     (btnDec),
      .btnClear   (btnClear),
      .value      (value),
      .valueStrobe(valueStrobe)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] val;
      int         at;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] probe_q[$];
   bit         done = 1'b0;
   int         checks = 0;
   int         errors = 0;

   localparam int BTN_LOAD = 0, BTN_INC = 1, BTN_DEC = 2, BTN_CLEAR = 3;
   localparam int LAT = 8;  // drive after edge c -> first sample c+1 -> strobe visible after edge c+8

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input int which, input logic lvl);
      case (which)
         BTN_LOAD:  btnLoad  = lvl;
         BTN_INC:   btnInc   = lvl;
         BTN_DEC:   btnDec   = lvl;
         default:   btnClear = lvl;
      endcase
   endtask

   task automatic expect_evt(input logic [7:0] v, input int delay);
      exp_t e;
      e.val = v;
      e.at  = cyc + delay;
      exp_q.push_back(e);
   endtask

   // Clean press of one button producing one expected update.
   task automatic tap(input int which, input logic [7:0] v);
      set_btn(which, 1'b1);
      expect_evt(v, LAT);
      tick(10);
      set_btn(which, 1'b0);
      tick(15);
   endtask

   task automatic probe(input logic [7:0] v);
      probe_q.push_back(v);
      tick(1);
   endtask

   // Stimulus
   initial begin
      reset = 1'b1; switches = 8'h00;
      btnLoad = 1'b0; btnInc = 1'b0; btnDec = 1'b0; btnClear = 1'b0;
      tick(3);
      probe(8'h00);
      reset = 1'b0;
      tick(2);

      // Held inc: one increment, no repeats in either build within 20 cycles
      btnInc = 1'b1;
      expect_evt(8'h01, LAT);
      tick(20);
      btnInc = 1'b0;
      tick(15);
      probe(8'h01);

      // Bounce 3 high / 1 low / 3 high: rejected
      btnInc = 1'b1; tick(3);
      btnInc = 1'b0; tick(1);
      btnInc = 1'b1; tick(3);
      btnInc = 1'b0; tick(12);
      probe(8'h01);
      btnInc = 1'b1;
      expect_evt(8'h02, LAT);
      tick(10);
      btnInc = 1'b0;
      tick(15);
      probe(8'h02);

      // Wrap-around both ways
      switches = 8'hFF; tick(3);
      tap(BTN_LOAD, 8'hFF);
      tap(BTN_INC,  8'h00);
      tap(BTN_DEC,  8'hFF);
      probe(8'hFF);

      // Inc+dec cancel; clear beats load
      switches = 8'h10; tick(3);
      tap(BTN_LOAD, 8'h10);
      btnInc = 1'b1; btnDec = 1'b1;
      tick(10);
      btnInc = 1'b0; btnDec = 1'b0;
      tick(15);
      probe(8'h10);
      switches = 8'hA5; tick(3);
      btnClear = 1'b1; btnLoad = 1'b1;
      expect_evt(8'h00, LAT);
      tick(10);
      btnClear = 1'b0; btnLoad = 1'b0;
      tick(15);
      probe(8'h00);
      tap(BTN_CLEAR, 8'h00);  // clear at zero still strobes
      tap(BTN_LOAD,  8'hA5);  // load samples current switches
      tap(BTN_LOAD,  8'hA5);  // reload of same value still strobes

      // Reset at debounce count 3 with inc held
      btnInc = 1'b1;
      tick(5);
      reset = 1'b1;
      tick(3);
      probe(8'h00);
      reset = 1'b0;
      expect_evt(8'h01, LAT);
      tick(15);
      btnInc = 1'b0;
      tick(15);
      probe(8'h01);

      // Long hold from zero
      tap(BTN_CLEAR, 8'h00);
      btnInc = 1'b1;
      expect_evt(8'h01, LAT);
`ifdef BINARY_ENCODER_AUTO_REPEAT_EN
      expect_evt(8'h02, LAT + 20);
      expect_evt(8'h03, LAT + 28);
      expect_evt(8'h04, LAT + 36);
      expect_evt(8'h05, LAT + 44);
      expect_evt(8'h06, LAT + 52);
`endif
      tick(60);
      btnInc = 1'b0;
      tick(20);
`ifdef BINARY_ENCODER_AUTO_REPEAT_EN
      probe(8'h06);
`else
      probe(8'h01);
`endif

      done = 1'b1;
      tick(5);
   end

   // Monitor: compares every strobe against the scoreboard and every probe
   // against the current value; owns all counters and the summary.
   exp_t       m_e;
   logic [7:0] m_p;
   always @(negedge clk) begin
      if (valueStrobe) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: value=%02h at cycle %0d, required no strobe", value, cyc);
         end else begin
            m_e = exp_q.pop_front();
            if (value !== m_e.val || cyc != m_e.at) begin
               errors++;
               $display("FAIL strobe_update: got value=%02h at cycle %0d, required value=%02h at cycle %0d",
                        value, cyc, m_e.val, m_e.at);
            end
         end
      end
      while (probe_q.size() > 0) begin
         m_p = probe_q.pop_front();
         checks++;
         if (value !== m_p || valueStrobe !== 1'b0) begin
            errors++;
            $display("FAIL quiet_probe: got value=%02h strobe=%b at cycle %0d, required value=%02h strobe=0",
                     value, valueStrobe, cyc, m_p);
         end
      end
      if (done || cyc > 2000) begin
         checks++;
         if (!done || exp_q.size() != 0) begin
            errors++;
            $display("FAIL completion: done=%0d pending_updates=%0d at cycle %0d, required done=1 pending=0",
                     done, exp_q.size(), cyc);
         end
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

endmodule
